// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the three handshake/bus groups around lsu_ctrl.
//   request  : i_req_valid/o_req_ready, i_req_addr, i_req_we, i_req_funct3, i_req_wdata
//   memory   : o_dmem_addr/en/we/funct/wdata, i_dmem_rdata
//   response : o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err, o_rsp_cause
// Modports:
//   slave  - the lsu_ctrl side (drives the o_* signals)
//   master - the pipeline/memory side (drives the i_* signals)
// DMEM_ADDR must match the DMEM_ADDR of the attached lsu_ctrl.
interface lsu_ctrl_if #(
    parameter int DMEM_ADDR = 13
);
    logic                 i_req_valid;
    logic                 o_req_ready;
    logic [31:0]          i_req_addr;
    logic                 i_req_we;
    logic [2:0]           i_req_funct3;
    logic [31:0]          i_req_wdata;

    logic [DMEM_ADDR-1:0] o_dmem_addr;
    logic                 o_dmem_en;
    logic                 o_dmem_we;
    logic [2:0]           o_dmem_funct;
    logic [31:0]          o_dmem_wdata;
    logic [31:0]          i_dmem_rdata;

    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [31:0]          o_rsp_rdata;
    logic                 o_rsp_err;
    logic [1:0]           o_rsp_cause;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_we, i_req_funct3, i_req_wdata,
        input  i_dmem_rdata, i_rsp_ready,
        output o_req_ready,
        output o_dmem_addr, o_dmem_en, o_dmem_we, o_dmem_funct, o_dmem_wdata,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_cause
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_we, i_req_funct3, i_req_wdata,
        output i_dmem_rdata, i_rsp_ready,
        input  o_req_ready,
        input  o_dmem_addr, o_dmem_en, o_dmem_we, o_dmem_funct, o_dmem_wdata,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_cause
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage between the MEM stage and a
// byte-addressed data memory. Takes one request at a time, validates it
// (funct3, alignment, range), performs a single one-cycle memory access for
// legal requests and returns a response; illegal requests get an error
// response with a cause and never touch memory.
//
// Ports:
//   i_clk  - clock, all state on the rising edge
//   i_rst  - asynchronous active-high reset
//   bus    - lsu_ctrl_if.slave (request, data memory and response groups)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN defined   - misaligned half/word requests return cause 01
//   LSU_MISALIGN_TRAP_EN undefined - misaligned requests are silently aligned down
//
// Response cause: 00 none, 01 misaligned, 10 out of range, 11 illegal funct3
module lsu_ctrl #(
    parameter int DMEM_ADDR = 13
) (
    input  logic      i_clk,
    input  logic      i_rst,
    lsu_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;
    localparam logic [1:0] CAUSE_FUNCT    = 2'b11;

    logic [1:0]           state;
    logic [DMEM_ADDR-1:0] addr_q;
    logic                 we_q;
    logic [2:0]           funct_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic [1:0]           cause_q;

    logic                 funct_ok;
    logic                 out_of_range;
    logic                 misal_err;
    logic [DMEM_ADDR-1:0] addr_lo;
    logic [1:0]           cause_in;

    always_comb begin
        if (bus.i_req_we)
            funct_ok = (bus.i_req_funct3 <= 3'd2);
        else
            funct_ok = (bus.i_req_funct3 != 3'd3) && (bus.i_req_funct3 != 3'd6) &&
                       (bus.i_req_funct3 != 3'd7);
    end

    assign out_of_range = |bus.i_req_addr[31:DMEM_ADDR];

    // funct3[1:0] is the access size for every legal encoding: 0 byte, 1 half, 2 word.
    always_comb begin
        addr_lo   = bus.i_req_addr[DMEM_ADDR-1:0];
        misal_err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misal_err = ((bus.i_req_funct3[1:0] == 2'b01) && bus.i_req_addr[0]) ||
                    ((bus.i_req_funct3[1:0] == 2'b10) && (bus.i_req_addr[1:0] != 2'b00));
`else
        case (bus.i_req_funct3[1:0])
            2'b01:   addr_lo[0]   = 1'b0;
            2'b10:   addr_lo[1:0] = 2'b00;
            default: ;
        endcase
`endif
        if (!funct_ok)
            cause_in = CAUSE_FUNCT;
        else if (misal_err)
            cause_in = CAUSE_MISALIGN;
        else if (out_of_range)
            cause_in = CAUSE_RANGE;
        else
            cause_in = CAUSE_NONE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            funct_q <= 3'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_req_valid) begin
                        addr_q  <= addr_lo;
                        we_q    <= bus.i_req_we;
                        funct_q <= bus.i_req_funct3;
                        wdata_q <= bus.i_req_wdata;
                        rdata_q <= 32'd0;
                        cause_q <= cause_in;
                        state   <= (cause_in != CAUSE_NONE) ? S_ERR : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_q)
                        rdata_q <= bus.i_dmem_rdata;
                    state <= S_RESP;
                end
                S_RESP, S_ERR: begin
                    if (bus.i_rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The reset term makes the memory select fall in the same instant reset
    // rises, so an in-flight store cannot commit on the next edge.
    assign bus.o_req_ready  = (state == S_IDLE);
    assign bus.o_dmem_en    = (state == S_ACCESS) && !i_rst;
    assign bus.o_dmem_we    = (state == S_ACCESS) && !i_rst && we_q;
    assign bus.o_dmem_addr  = addr_q;
    assign bus.o_dmem_funct = funct_q;
    assign bus.o_dmem_wdata = wdata_q;

    assign bus.o_rsp_valid  = (state == S_RESP) || (state == S_ERR);
    assign bus.o_rsp_err    = (state == S_ERR);
    assign bus.o_rsp_cause  = (state == S_ERR) ? cause_q : CAUSE_NONE;
    assign bus.o_rsp_rdata  = (state == S_RESP) ? rdata_q : 32'd0;
endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    localparam int AW   = 13;
    localparam int MEMB = 1 << AW;

    logic i_clk;
    logic i_rst;

    lsu_ctrl_if #(.DMEM_ADDR(AW)) bus ();

    lsu_ctrl #(.DMEM_ADDR(AW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        int          en_n;
        logic [AW-1:0] addr;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;

    // ---------------- memory behind the DUT ----------------
    logic [7:0]    dmem_arr [0:MEMB-1];
    logic [AW-1:0] ma;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   rd;

    always_comb begin
        ma = bus.o_dmem_addr;
        b0 = dmem_arr[ma];
        b1 = dmem_arr[ma + 13'd1];
        b2 = dmem_arr[ma + 13'd2];
        b3 = dmem_arr[ma + 13'd3];
        case (bus.o_dmem_funct)
            3'd0:    rd = {{24{b0[7]}}, b0};
            3'd4:    rd = {24'd0, b0};
            3'd1:    rd = {{16{b1[7]}}, b1, b0};
            3'd5:    rd = {16'd0, b1, b0};
            default: rd = {b3, b2, b1, b0};
        endcase
    end
    assign bus.i_dmem_rdata = rd;

    always @(posedge i_clk) begin
        if (bus.o_dmem_en && bus.o_dmem_we) begin
            dmem_arr[bus.o_dmem_addr] <= bus.o_dmem_wdata[7:0];
            if (bus.o_dmem_funct[1:0] != 2'b00)
                dmem_arr[bus.o_dmem_addr + 13'd1] <= bus.o_dmem_wdata[15:8];
            if (bus.o_dmem_funct[1:0] == 2'b10) begin
                dmem_arr[bus.o_dmem_addr + 13'd2] <= bus.o_dmem_wdata[23:16];
                dmem_arr[bus.o_dmem_addr + 13'd3] <= bus.o_dmem_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:MEMB-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic ref_model(input logic [31:0] a_in, input logic we, input logic [2:0] f,
                             input logic [31:0] wd, output exp_t e);
        logic [31:0] a;
        int          nb;
        bit          legal, mis, oor;
        logic [31:0] v;
        a  = a_in;
        nb = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f <= 3'd2) : !(f == 3'd3 || f == 3'd6 || f == 3'd7);
        mis   = (a % nb) != 0;
        oor   = a >= MEMB;
        e.rdata = 32'd0; e.err = 1'b0; e.cause = 2'b00; e.en_n = 1; e.we = we;
`ifndef LSU_MISALIGN_TRAP_EN
        if (mis) a = a - (a % nb);
        mis = 1'b0;
`endif
        e.addr = a[AW-1:0];
        if (!legal)    begin e.err = 1'b1; e.cause = 2'b11; end
        else if (mis)  begin e.err = 1'b1; e.cause = 2'b01; end
        else if (oor)  begin e.err = 1'b1; e.cause = 2'b10; end
        if (e.err) begin
            e.en_n = 0;
        end else if (we) begin
            for (int k = 0; k < nb; k++) ref_mem[a + k] = wd[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < nb; k++) v = v + (32'(ref_mem[a + k]) << (8 * k));
            if (f == 3'd0 && v >= 32'd128)   v = v - 32'd256;
            if (f == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            e.rdata = v;
        end
    endtask

    // ---------------- monitor ----------------
    int          en_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_rdata;
    logic        prev_err;
    logic [1:0]  prev_cause;

    always @(negedge i_clk) begin
        if (i_rst) begin
            en_cnt = 0;
            prev_stall = 0;
        end else begin
            if (bus.o_dmem_en) begin
                en_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_dmem_en", 32'd1, 32'd0);
                end else begin
                    chk("dmem_addr", 32'(bus.o_dmem_addr), 32'(exp_q[0].addr));
                    chk("dmem_we", 32'(bus.o_dmem_we), 32'(exp_q[0].we));
                end
            end
            if (bus.o_rsp_valid) begin
                chk("req_ready_busy", 32'(bus.o_req_ready), 32'd0);
                if (prev_stall) begin
                    chk("stable_rdata", bus.o_rsp_rdata, prev_rdata);
                    chk("stable_err", 32'(bus.o_rsp_err), 32'(prev_err));
                    chk("stable_cause", 32'(bus.o_rsp_cause), 32'(prev_cause));
                end
                if (bus.i_rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_without_req", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_rdata", bus.o_rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(bus.o_rsp_err), 32'(e.err));
                        chk("rsp_cause", 32'(bus.o_rsp_cause), 32'(e.cause));
                        chk("dmem_en_cycles", 32'(en_cnt), 32'(e.en_n));
                    end
                    en_cnt = 0;
                    done_cnt++;
                end
                prev_stall = !bus.i_rsp_ready;
                prev_rdata = bus.o_rsp_rdata;
                prev_err   = bus.o_rsp_err;
                prev_cause = bus.o_rsp_cause;
            end else begin
                prev_stall = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [31:0] a, input logic we, input logic [2:0] f,
                          input logic [31:0] wd, input int hold);
        exp_t e;
        int   t, vc, old;
        @(posedge i_clk); #1;
        bus.i_req_valid  = 1'b1;
        bus.i_req_addr   = a;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f;
        bus.i_req_wdata  = wd;
        t = 0;
        while (!bus.o_req_ready && t < 20) begin
            @(posedge i_clk); #1; t++;
        end
        if (!bus.o_req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            bus.i_req_valid = 1'b0;
            return;
        end
        ref_model(a, we, f, wd, e);
        exp_q.push_back(e);
        old = done_cnt;
        @(posedge i_clk); #1;
        bus.i_req_valid = 1'b0;
        t = 0; vc = 0;
        while (done_cnt == old && t < 50) begin
            if (bus.o_rsp_valid) begin
                if (vc >= hold) bus.i_rsp_ready = 1'b1;
                vc++;
            end
            @(posedge i_clk); #1; t++;
        end
        if (done_cnt == old) chk("rsp_timeout", 32'd0, 32'd1);
        bus.i_rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.o_req_ready), 32'd1);
        chk({tag, "_dmem_en"},   32'(bus.o_dmem_en),   32'd0);
        chk({tag, "_dmem_we"},   32'(bus.o_dmem_we),   32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd0);
        chk({tag, "_rsp_err"},   32'(bus.o_rsp_err),   32'd0);
        chk({tag, "_rsp_cause"}, 32'(bus.o_rsp_cause), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.o_rsp_rdata,      32'd0);
        chk({tag, "_dmem_addr"}, 32'(bus.o_dmem_addr), 32'd0);
        chk({tag, "_dmem_funct"}, 32'(bus.o_dmem_funct), 32'd0);
        chk({tag, "_dmem_wdata"}, bus.o_dmem_wdata,    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < MEMB; i++) begin
            dmem_arr[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        bus.i_req_valid  = 1'b0;
        bus.i_req_addr   = 32'd0;
        bus.i_req_we     = 1'b0;
        bus.i_req_funct3 = 3'd0;
        bus.i_req_wdata  = 32'd0;
        bus.i_rsp_ready  = 1'b0;
        i_rst = 1'b1;
        #23;
        chk_reset_vals("reset");
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        do_req(32'h100, 1'b1, 3'd2, 32'hDEADBEEF, 0);
        do_req(32'h100, 1'b0, 3'd2, 32'd0, 0);
        do_req(32'h103, 1'b0, 3'd0, 32'd0, 0);
        do_req(32'h103, 1'b0, 3'd4, 32'd0, 0);
        do_req(32'h102, 1'b0, 3'd2, 32'd0, 0);
        do_req(32'h2000, 1'b0, 3'd2, 32'd0, 0);
        do_req(32'h2001, 1'b1, 3'd4, 32'h1234, 0);
        do_req(32'h100, 1'b0, 3'd2, 32'd0, 3);
        do_req(32'h1FFC, 1'b1, 3'd2, 32'hA5B6C7D8, 1);
        do_req(32'h1FFC, 1'b0, 3'd2, 32'd0, 0);
        do_req(32'h1FFF, 1'b1, 3'd0, 32'h0000_0080, 0);
        do_req(32'h1FFF, 1'b0, 3'd0, 32'd0, 0);
        do_req(32'h1FFF, 1'b0, 3'd4, 32'd0, 2);

        // Store killed by reset while in its access cycle
        @(posedge i_clk); #1;
        bus.i_req_valid  = 1'b1;
        bus.i_req_addr   = 32'h10;
        bus.i_req_we     = 1'b1;
        bus.i_req_funct3 = 3'd0;
        bus.i_req_wdata  = 32'h55;
        @(posedge i_clk); #1;
        bus.i_req_valid = 1'b0;
        chk("rst_pre_dmem_en", 32'(bus.o_dmem_en), 32'd1);
        i_rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        do_req(32'h10, 1'b0, 3'd4, 32'd0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0)
                a = $urandom | 32'h0000_2000;
            else
                a = 32'h1F00 + 32'($urandom_range(0, 255));
            do_req(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge i_clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
